washer_plant_model: RTL and testbench
=====================================

Name: washer_plant_model

Overview:
- Behavioural plant model for the washer controller: the sensor end of the valve/shake/turn ↔ full/Time/dry interface.
- Consumes the controller's actuator commands (valve, shake_mode, turn_mode).
- Produces the sensor inputs the controller waits on (full, Time, dry) from internal water-level and timer counters.
- Used in closed-loop simulation and on FPGA to exercise the controller without external hardware.

Parameters:
- FILL_CYCLES, 8: valve-open cycles to go from empty to full; also drain cycles from full to empty.
- SHAKE_CYCLES, 16: agitation cycles before Time asserts.
- DRY_CYCLES, 12: spin cycles after level reaches 0 before dry asserts.
- CNT_W, 8: width of level and timer counters. Requires FILL_CYCLES, SHAKE_CYCLES, DRY_CYCLES in range 1..2^CNT_W-1.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- valve  input  1  fill valve command.
- shake_mode  input  1  agitate command.
- turn_mode  input  1  spin/drain command.
- full  output  1  tank full: level == FILL_CYCLES.
- Time  output  1  agitation time elapsed.
- dry  output  1  spin-dry complete.
- level  output  CNT_W  current water level, 0..FILL_CYCLES.
- fault  output  1  sticky illegal-command flag.

Behaviour:
- Reset (reset=1 at a rising edge): level=0, shake_cnt=0, dry_cnt=0, fault=0, overflow counter=0. Hence full=Time=dry=0. Reset has priority over everything and aborts any operation in progress.
- All outputs are Moore: decoded from registers only. There is no combinational path from inputs to outputs. A command sampled at edge k affects outputs after edge k.
- Mode decode each edge:
  - IDLE: no command.
  - FILL: valve only.
  - AGITATE: shake_mode only.
  - SPIN: turn_mode only.
  - ILLEGAL: two or more commands high.
- FILL: level increments by 1 per edge, saturating at FILL_CYCLES. full=1 exactly when level==FILL_CYCLES.
- AGITATE: level held. shake_cnt increments per edge, saturating at SHAKE_CYCLES. Time=1 when shake_cnt==SHAKE_CYCLES.
- Any edge with shake_mode=0 clears shake_cnt to 0, so Time deasserts the cycle after agitation stops.
- SPIN, level>0: level decrements by 1 per edge; dry_cnt held at 0.
- SPIN, level==0: dry_cnt increments per edge, saturating at DRY_CYCLES. dry=1 when dry_cnt==DRY_CYCLES.
- Any edge with turn_mode=0 clears dry_cnt.
- Spin from full: dry asserts FILL_CYCLES+DRY_CYCLES edges after turn_mode is first sampled high.
- IDLE: level held; shake_cnt and dry_cnt cleared per the rules above.
- ILLEGAL: fault set at that edge and stays set until reset.
- While fault=1: level and all counters frozen; full, Time and dry forced to 0; level output still shows the frozen value.
- Boundaries:
  - valve at full: level stays FILL_CYCLES, no wrap.
  - turn_mode at level 0: no underflow.
  - Return to FILL mid-drain: resumes incrementing from the current level.
  - Spin interrupted after dry asserts: dry_cnt cleared; re-entering SPIN at level 0 requires a full DRY_CYCLES again.

Optional Feature:
- Macro: WASHER_OVERFLOW_CHECK_EN.
- Defined: an overflow counter counts consecutive edges with valve=1 while level==FILL_CYCLES. It clears on any edge where that condition is false.
- When the counter reaches 3, fault is set with the same sticky semantics as ILLEGAL. One or two such edges are legal grace, covering the controller's one-cycle response to full.
- Not defined: no overflow counter is built, and valve at full only saturates.

Test Plan:
- Reset, then valve=1 held 10 cycles -> level counts 1..8, full=1 from the 8th edge, level stays 8, fault=0.
- After full, shake_mode=1 for 20 cycles -> Time=1 after 16th edge, held; shake_mode=0 -> Time=0 after next edge, level stays 8.
- From level 8, turn_mode=1 -> level reaches 0 after 8 edges; dry=1 after 20th edge; turn_mode=0 -> dry=0 next cycle.
- valve=1 and turn_mode=1 at level 5 -> fault=1 next cycle, level frozen at 5, full/Time/dry=0; reset=1 one cycle -> all outputs 0.
- reset asserted at shake_cnt=10 -> shake_cnt=0, Time=0, level=0; re-agitating needs the full 16 cycles.
- WASHER_OVERFLOW_CHECK_EN defined: valve held 2 cycles past full -> fault=0; held 3 cycles past full -> fault=1. Undefined: valve held 50 cycles past full -> fault=0.

Source files
------------

// File: rtl/washer_plant_model.sv
// Washer plant model: turns valve/shake/turn commands into full/Time/dry sensor outputs. Optional WASHER_OVERFLOW_CHECK_EN faults on valve held at full.
// Latency: every output is registered and moves on the edge after the command is sampled.
// Backpressure: none; a command is consumed on every edge and there is no handshake.
module washer_plant_model #(
  parameter int FILL_CYCLES  = 8,
  parameter int SHAKE_CYCLES = 16,
  parameter int DRY_CYCLES   = 12,
  parameter int CNT_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valve,
  input  logic             shake_mode,
  input  logic             turn_mode,
  output logic             full,
  output logic             Time,
  output logic             dry,
  output logic [CNT_W-1:0] level,
  output logic             fault
);

  typedef enum logic [2:0] {
    MODE_IDLE,
    MODE_FILL,
    MODE_AGITATE,
    MODE_SPIN,
    MODE_ILLEGAL
  } mode_e;

  localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(FILL_CYCLES);
  localparam logic [CNT_W-1:0] SHAKE_MAX = CNT_W'(SHAKE_CYCLES);
  localparam logic [CNT_W-1:0] DRY_MAX   = CNT_W'(DRY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  mode_e            mode;
  logic [CNT_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] shake_cnt_q, shake_cnt_d;
  logic [CNT_W-1:0] dry_cnt_q, dry_cnt_d;
  logic             fault_q, fault_d;
  logic             ovf_trip;

  always_comb begin
    mode = MODE_ILLEGAL;
    case ({valve, shake_mode, turn_mode})
      3'b000:  mode = MODE_IDLE;
      3'b100:  mode = MODE_FILL;
      3'b010:  mode = MODE_AGITATE;
      3'b001:  mode = MODE_SPIN;
      default: mode = MODE_ILLEGAL;
    endcase
  end

`ifdef WASHER_OVERFLOW_CHECK_EN
  // Two edges of valve-at-full are tolerated: the controller needs a cycle to react to full.
  logic [1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    ovf_trip  = 1'b0;
    if (!fault_q) begin
      if (valve && (level_q == FILL_MAX)) begin
        ovf_cnt_d = (ovf_cnt_q == 2'd3) ? 2'd3 : ovf_cnt_q + 2'd1;
        ovf_trip  = (ovf_cnt_d == 2'd3);
      end else begin
        ovf_cnt_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_cnt_q <= 2'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end
`else
  assign ovf_trip = 1'b0;
`endif

  always_comb begin
    level_d     = level_q;
    shake_cnt_d = shake_cnt_q;
    dry_cnt_d   = dry_cnt_q;
    fault_d     = fault_q;
    // Once faulted the plant freezes until reset.
    if (!fault_q) begin
      case (mode)
        MODE_FILL: begin
          level_d     = (level_q == FILL_MAX) ? level_q : level_q + CNT_ONE;
          shake_cnt_d = CNT_ZERO;
          dry_cnt_d   = CNT_ZERO;
        end
        MODE_AGITATE: begin
          shake_cnt_d = (shake_cnt_q == SHAKE_MAX) ? shake_cnt_q : shake_cnt_q + CNT_ONE;
          dry_cnt_d   = CNT_ZERO;
        end
        MODE_SPIN: begin
          shake_cnt_d = CNT_ZERO;
          if (level_q != CNT_ZERO) begin
            level_d   = level_q - CNT_ONE;
            dry_cnt_d = CNT_ZERO;
          end else begin
            dry_cnt_d = (dry_cnt_q == DRY_MAX) ? dry_cnt_q : dry_cnt_q + CNT_ONE;
          end
        end
        MODE_ILLEGAL: begin
          fault_d = 1'b1;
        end
        default: begin
          shake_cnt_d = CNT_ZERO;
          dry_cnt_d   = CNT_ZERO;
        end
      endcase
      if (ovf_trip) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q     <= CNT_ZERO;
      shake_cnt_q <= CNT_ZERO;
      dry_cnt_q   <= CNT_ZERO;
      fault_q     <= 1'b0;
    end else begin
      level_q     <= level_d;
      shake_cnt_q <= shake_cnt_d;
      dry_cnt_q   <= dry_cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign level = level_q;
  assign fault = fault_q;
  assign full  = !fault_q && (level_q == FILL_MAX);
  assign Time  = !fault_q && (shake_cnt_q == SHAKE_MAX);
  assign dry   = !fault_q && (dry_cnt_q == DRY_MAX);

endmodule

// File: tb/tb_washer_plant_model.sv
// Randomized and directed bench for washer_plant_model against a rule-level reference model.
module tb_washer_plant_model;

  localparam int F = 8;
  localparam int S = 16;
  localparam int D = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       valve = 1'b0;
  logic       shake_mode = 1'b0;
  logic       turn_mode = 1'b0;
  logic       full, Time, dry, fault;
  logic [7:0] level;

  int total = 0;
  int bad = 0;

  // Reference model: plain integer counts following the plant rules.
  int m_level = 0;
  int m_shake = 0;
  int m_dry = 0;
  int m_ovf = 0;
  bit m_fault = 0;

  washer_plant_model #(
    .FILL_CYCLES(F), .SHAKE_CYCLES(S), .DRY_CYCLES(D), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .valve(valve), .shake_mode(shake_mode),
    .turn_mode(turn_mode), .full(full), .Time(Time), .dry(dry),
    .level(level), .fault(fault)
  );

  always #5 clock = ~clock;

  task automatic model_step(input bit v, input bit s, input bit t);
    int n;
    if (m_fault) return;
    n = int'(v) + int'(s) + int'(t);
`ifdef WASHER_OVERFLOW_CHECK_EN
    if (v && m_level == F) m_ovf = m_ovf + 1;
    else m_ovf = 0;
    if (m_ovf >= 3) m_fault = 1;
`endif
    if (n >= 2) begin
      m_fault = 1;
      return;
    end
    if (m_fault) return;
    if (v) begin
      if (m_level < F) m_level++;
      m_shake = 0; m_dry = 0;
    end else if (s) begin
      if (m_shake < S) m_shake++;
      m_dry = 0;
    end else if (t) begin
      m_shake = 0;
      if (m_level > 0) begin
        m_level--;
        m_dry = 0;
      end else if (m_dry < D) begin
        m_dry++;
      end
    end else begin
      m_shake = 0; m_dry = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; valve = 1'b0; shake_mode = 1'b0; turn_mode = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    m_level = 0; m_shake = 0; m_dry = 0; m_ovf = 0; m_fault = 0;
  endtask

  task automatic step(input bit v, input bit s, input bit t);
    valve = v; shake_mode = s; turn_mode = t;
    @(posedge clock); #1;
    model_step(v, s, t);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (level !== 8'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++;
    if ({full, Time, dry, fault} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {full, Time, dry, fault});
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 0);
      total++;
      if (level !== 8'((i < F) ? i : F) || full !== (i >= F) || fault !== 1'b0) begin
        bad++;
        $display("FAIL fill_%0d got level=%0d full=%b fault=%b exp level=%0d full=%b fault=0",
                 i, level, full, fault, (i < F) ? i : F, (i >= F));
      end
    end
  endtask

  task automatic test_agitate();
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0);
      total++;
      if (Time !== (i >= S) || level !== 8'(F)) begin
        bad++;
        $display("FAIL agitate_%0d got Time=%b level=%0d exp Time=%b level=%0d",
                 i, Time, level, (i >= S), F);
      end
    end
    step(0, 0, 0);
    total++;
    if (Time !== 1'b0 || level !== 8'(F)) begin
      bad++; $display("FAIL agitate_stop got Time=%b level=%0d exp Time=0 level=%0d", Time, level, F);
    end
  endtask

  task automatic test_spin();
    for (int i = 1; i <= 22; i++) begin
      step(0, 0, 1);
      total++;
      if (level !== 8'((F - i > 0) ? F - i : 0) || dry !== (i >= F + D)) begin
        bad++;
        $display("FAIL spin_%0d got level=%0d dry=%b exp level=%0d dry=%b",
                 i, level, dry, (F - i > 0) ? F - i : 0, (i >= F + D));
      end
    end
    step(0, 0, 0);
    total++;
    if (dry !== 1'b0) begin bad++; $display("FAIL spin_stop got dry=%b exp 0", dry); end
    // Re-entering spin at level 0 needs the full dry count again.
    for (int i = 1; i <= D; i++) begin
      step(0, 0, 1);
      total++;
      if (dry !== (i == D)) begin
        bad++; $display("FAIL respin_%0d got dry=%b exp %b", i, dry, (i == D));
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(1, 0, 1);
    total++;
    if (fault !== 1'b1 || level !== 8'd5 || {full, Time, dry} !== 3'b000) begin
      bad++; $display("FAIL illegal got fault=%b level=%0d ftd=%b exp fault=1 level=5 ftd=000",
                      fault, level, {full, Time, dry});
    end
    for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    total++;
    if (fault !== 1'b1 || level !== 8'd5) begin
      bad++; $display("FAIL illegal_frozen got fault=%b level=%0d exp fault=1 level=5", fault, level);
    end
    do_reset();
    total++;
    if ({full, Time, dry, fault} !== 4'b0000 || level !== 8'd0) begin
      bad++; $display("FAIL illegal_reset got flags=%b level=%0d exp flags=0000 level=0",
                      {full, Time, dry, fault}, level);
    end
  endtask

  task automatic test_reset_midshake();
    do_reset();
    for (int i = 0; i < F; i++) step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    valve = 1'b0; shake_mode = 1'b1; turn_mode = 1'b0;
    do_reset();
    total++;
    if (Time !== 1'b0 || level !== 8'd0) begin
      bad++; $display("FAIL midshake_reset got Time=%b level=%0d exp Time=0 level=0", Time, level);
    end
    for (int i = 1; i <= S; i++) begin
      step(0, 1, 0);
      total++;
      if (Time !== (i == S)) begin
        bad++; $display("FAIL reagitate_%0d got Time=%b exp %b", i, Time, (i == S));
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < F + 2; i++) step(1, 0, 0);
    total++;
    if (fault !== 1'b0 || full !== 1'b1) begin
      bad++; $display("FAIL ovf_grace got fault=%b full=%b exp fault=0 full=1", fault, full);
    end
`ifdef WASHER_OVERFLOW_CHECK_EN
    step(1, 0, 0);
    total++;
    if (fault !== 1'b1 || full !== 1'b0 || level !== 8'(F)) begin
      bad++; $display("FAIL ovf_trip got fault=%b full=%b level=%0d exp fault=1 full=0 level=%0d",
                      fault, full, level, F);
    end
`else
    for (int i = 0; i < 48; i++) step(1, 0, 0);
    total++;
    if (fault !== 1'b0 || full !== 1'b1 || level !== 8'(F)) begin
      bad++; $display("FAIL ovf_saturate got fault=%b full=%b level=%0d exp fault=0 full=1 level=%0d",
                      fault, full, level, F);
    end
`endif
  endtask

  task automatic test_random();
    bit v, s, t;
    int r, len;
    do_reset();
    for (int run = 0; run < 60; run++) begin
      r = $urandom_range(0, 99);
      len = $urandom_range(1, 24);
      v = 0; s = 0; t = 0;
      if (r < 3) begin
        do_reset();
        len = 0;
      end else if (r < 6) begin
        v = 1'($urandom_range(0, 1)); s = 1; t = 1'($urandom_range(0, 1));
        len = 1;
      end else if (r < 35) v = 1;
      else if (r < 55) s = 1;
      else if (r < 85) t = 1;
      for (int k = 0; k < len; k++) begin
        step(v, s, t);
        total++;
        if (level !== 8'(m_level) || fault !== m_fault ||
            full !== (!m_fault && m_level == F) ||
            Time !== (!m_fault && m_shake == S) ||
            dry !== (!m_fault && m_dry == D)) begin
          bad++;
          $display("FAIL random_%0d_%0d cmd=%b%b%b got level=%0d f/T/d/flt=%b%b%b%b exp level=%0d f/T/d/flt=%b%b%b%b",
                   run, k, v, s, t, level, full, Time, dry, fault, m_level,
                   (!m_fault && m_level == F), (!m_fault && m_shake == S),
                   (!m_fault && m_dry == D), m_fault);
        end
      end
      if (m_fault && $urandom_range(0, 1) == 1) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_agitate();
    test_spin();
    test_illegal();
    test_reset_midshake();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
